eje6_demux_tdm: RTL

Sequential 1-to-4 time-division demultiplexer, the receiving end of the 4:1 multiplexer link. It accepts one serial data word per enabled cycle on `f`, aligns to a frame-start marker, and reconstructs the four channels `w0`..`w3`. Each complete frame is presented atomically on registered outputs with a one-cycle `valid` strobe. It sits directly downstream of the 4:1 mux whose selectors are driven by a 2-bit slot counter.

---
 rtl/eje6_pkg.sv | 13 +
 rtl/eje6_slot_cnt.sv | 27 ++
 rtl/eje6_demux_tdm.sv | 120 ++++++++++++
 3 files changed

// File: rtl/eje6_pkg.sv
// Shared definitions for the eje6 TDM link: receiver state encoding and
// slot bounds, also used by the 4:1 mux benches for selector sequencing.
package eje6_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam logic [1:0] SLOT_FIRST = 2'd0;
   localparam logic [1:0] SLOT_LAST  = 2'd3;

endpackage

// File: rtl/eje6_slot_cnt.sv
// 2-bit slot counter for the TDM demux: wraps 3->0 on increment and
// restarts at slot 1 when a frame-start sample has just been taken as slot 0.
module eje6_slot_cnt
   import eje6_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       inc,
   input  logic       load1,
   output logic [1:0] slot,
   output logic       last
);

   // Load takes priority: a sync sample always re-bases the frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         slot <= SLOT_FIRST;
      end else if (load1) begin
         slot <= 2'd1;
      end else if (inc) begin
         slot <= slot + 2'd1;
      end
   end

   assign last = (slot == SLOT_LAST);

endmodule

// File: rtl/eje6_demux_tdm.sv
// 1-to-4 time-division demultiplexer: aligns to a frame-start marker and
// presents each complete frame atomically on registered outputs.
module eje6_demux_tdm
   import eje6_pkg::*;
#(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] f,
   input  logic         en,
   input  logic         sync,
   output logic [W-1:0] w0,
   output logic [W-1:0] w1,
   output logic [W-1:0] w2,
   output logic [W-1:0] w3,
   output logic         valid,
   output logic         s1,
   output logic         s0,
   output logic         err
);

   state_t       state_q;
   state_t       state_d;
   logic [1:0]   slot;
   logic         last;
   logic         inc;
   logic         load1;
   logic         frame_done;
   logic         frame_err;
   logic [W-1:0] sh0;
   logic [W-1:0] sh1;
   logic [W-1:0] sh2;

   eje6_slot_cnt u_slot_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (inc),
      .load1 (load1),
      .slot  (slot),
      .last  (last)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      inc        = 1'b0;
      load1      = 1'b0;
      frame_done = 1'b0;
      frame_err  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (en && sync) begin
               load1   = 1'b1;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (en) begin
               if (sync) begin
                  load1     = 1'b1;
                  frame_err = (slot != SLOT_FIRST);
               end else begin
                  inc        = 1'b1;
                  frame_done = last;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Slot 3 never lands here; it goes straight to w3 on frame completion.
   always_ff @(posedge clk) begin
      if (rst) begin
         sh0 <= '0;
         sh1 <= '0;
         sh2 <= '0;
      end else if (load1) begin
         sh0 <= f;
      end else if (inc) begin
         case (slot)
            2'd0:    sh0 <= f;
            2'd1:    sh1 <= f;
            2'd2:    sh2 <= f;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         w0    <= '0;
         w1    <= '0;
         w2    <= '0;
         w3    <= '0;
         valid <= 1'b0;
         err   <= 1'b0;
      end else begin
         valid <= frame_done;
         err   <= frame_err;
         if (frame_done) begin
            w0 <= sh0;
            w1 <= sh1;
            w2 <= sh2;
            w3 <= f;
         end
      end
   end

   assign {s1, s0} = slot;

endmodule
